// File: rtl/immediate_gen.sv
// ---------------------------------------------------------------------------
// immediate_gen
//
// Purpose:
//   Decodes an RV32I instruction word into its sign-extended immediate and
//   format code. The result is registered, so outputs appear one clock after
//   the instruction is captured. Branch (SB) and jump (UJ) offsets come out
//   right-aligned, without the implicit <<1. The branch/jump adder applies
//   that shift.
//
// Ports:
//   clk               in   1   single clock, rising-edge active
//   rst_n             in   1   synchronous active-low reset
//   in_valid          in   1   instruction qualifier (capture when high)
//   instruction       in  32   RV32I instruction word, opcode = [6:0]
//   out_valid         out  1   high the cycle after a captured instruction
//   signExtnImmediate out 32   registered immediate
//   imm_type          out  3   registered format: 0 R, 1 I, 2 S, 3 SB,
//                              4 U, 5 UJ, 7 illegal
//   illegal           out  1   registered, high iff imm_type == 7
//
// Handshake:
//   There is no backpressure. An instruction is taken on every rising edge
//   where in_valid is high. out_valid follows in_valid with a one-cycle delay.
//   While out_valid is low, the data outputs keep their last captured value.
// ---------------------------------------------------------------------------
module immediate_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    output logic        out_valid,
    output logic [31:0] signExtnImmediate,
    output logic [2:0]  imm_type,
    output logic        illegal
);

    localparam logic [2:0] TYPE_R   = 3'd0;
    localparam logic [2:0] TYPE_I   = 3'd1;
    localparam logic [2:0] TYPE_S   = 3'd2;
    localparam logic [2:0] TYPE_SB  = 3'd3;
    localparam logic [2:0] TYPE_U   = 3'd4;
    localparam logic [2:0] TYPE_UJ  = 3'd5;
    localparam logic [2:0] TYPE_ILL = 3'd7;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0]  w_opcode;
    logic [2:0]  w_type;
    logic [31:0] w_imm;

    logic        r_valid;
    logic [31:0] r_imm;
    logic [2:0]  r_type;
    logic        r_illegal;

    assign w_opcode = instruction[6:0];

    // Format decode and immediate assembly for the incoming word.
    always_comb begin
        w_type = TYPE_ILL;
        w_imm  = 32'h0000_0000;
        case (w_opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: begin
                w_type = TYPE_I;
                w_imm  = {{20{instruction[31]}}, instruction[31:20]};
            end
            OP_STORE: begin
                w_type = TYPE_S;
                w_imm  = {{20{instruction[31]}}, instruction[31:25],
                          instruction[11:7]};
            end
            OP_BRANCH: begin
                // Offset bits [12:1] packed into a 12-bit field, unshifted.
                w_type = TYPE_SB;
                w_imm  = {{20{instruction[31]}}, instruction[31],
                          instruction[7], instruction[30:25],
                          instruction[11:8]};
            end
            OP_LUI, OP_AUIPC: begin
                w_type = TYPE_U;
                w_imm  = {instruction[31:12], 12'h000};
            end
            OP_JAL: begin
                // Offset bits [20:1] packed into a 20-bit field, unshifted.
                w_type = TYPE_UJ;
                w_imm  = {{12{instruction[31]}}, instruction[31],
                          instruction[19:12], instruction[20],
                          instruction[30:21]};
            end
            OP_REG: begin
                w_type = TYPE_R;
                w_imm  = 32'h0000_0000;
            end
            default: begin
                w_type = TYPE_ILL;
                w_imm  = 32'h0000_0000;
            end
        endcase
    end

    // Reset wins over capture. When in_valid is low, only the valid flag
    // drops and the data registers hold their contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_imm     <= 32'h0000_0000;
            r_type    <= TYPE_R;
            r_illegal <= 1'b0;
        end else if (in_valid) begin
            r_valid   <= 1'b1;
            r_imm     <= w_imm;
            r_type    <= w_type;
            r_illegal <= (w_type == TYPE_ILL);
        end else begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid         = r_valid;
    assign signExtnImmediate = r_imm;
    assign imm_type          = r_type;
    assign illegal           = r_illegal;

endmodule

// File: tb/tb_immediate_gen.sv
module tb_immediate_gen;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instruction;
  logic        out_valid;
  logic [31:0] signExtnImmediate;
  logic [2:0]  imm_type;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  // Expected output state per cycle: {valid, illegal, type[2:0], imm[31:0]}
  logic [36:0] exp_q[$];

  // Reference output state, advanced once per rising edge
  logic        m_valid;
  logic        m_illegal;
  logic [2:0]  m_type;
  logic [31:0] m_imm;

  immediate_gen dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .instruction       (instruction),
    .out_valid         (out_valid),
    .signExtnImmediate (signExtnImmediate),
    .imm_type          (imm_type),
    .illegal           (illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works from the ISA view: rebuild the byte offset the instruction encodes,
  // then halve it for branch/jump formats.
  function automatic logic [35:0] ref_decode(input logic [31:0] ins);
    int          v;
    logic [2:0]  t;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin
        t = 3'd1;
        v = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
      end
      7'h23: begin
        t = 3'd2;
        v = int'(ins[31:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 4096 : 0);
      end
      7'h63: begin
        t = 3'd3;
        v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
            + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        v = v / 2;
      end
      7'h37, 7'h17: begin
        t = 3'd4;
        v = int'(ins & 32'hFFFF_F000);
      end
      7'h6F: begin
        t = 3'd5;
        v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096
            + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        v = v / 2;
      end
      7'h33: begin
        t = 3'd0;
        v = 0;
      end
      default: begin
        t = 3'd7;
        v = 0;
      end
    endcase
    return {(t == 3'd7), t, 32'(v)};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic rst, input logic v, input logic [31:0] ins);
    logic [35:0] d;
    logic [36:0] e;
    @(negedge clk);
    rst_n       = rst;
    in_valid    = v;
    instruction = ins;
    if (!rst) begin
      m_valid = 1'b0; m_illegal = 1'b0; m_type = 3'd0; m_imm = 32'h0;
    end else if (v) begin
      d = ref_decode(ins);
      m_valid = 1'b1; m_illegal = d[35]; m_type = d[34:32]; m_imm = d[31:0];
    end else begin
      m_valid = 1'b0;
    end
    exp_q.push_back({m_valid, m_illegal, m_type, m_imm});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("out_valid", 32'(out_valid), 32'(e[36]));
    check("illegal",   32'(illegal),   32'(e[35]));
    check("imm_type",  32'(imm_type),  32'(e[34:32]));
    check("imm",       signExtnImmediate, e[31:0]);
  endtask

  // Directed vector: model check plus comparison against fixed constants
  task automatic directed(input logic [31:0] ins, input logic [31:0] eimm, input logic [2:0] et);
    drive_cycle(1'b1, 1'b1, ins);
    check("dir_imm",  signExtnImmediate, eimm);
    check("dir_type", 32'(imm_type), 32'(et));
    check("dir_ill",  32'(illegal), 32'(et == 3'd7));
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23,
                           7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

  initial begin
    logic [31:0] ins;
    logic [31:0] held;
    rst_n = 1'b0; in_valid = 1'b0; instruction = 32'h0;
    m_valid = 1'b0; m_illegal = 1'b0; m_type = 3'd0; m_imm = 32'h0;

    // Reset with in_valid high and a non-zero instruction
    drive_cycle(1'b0, 1'b1, 32'hE070_0013);
    drive_cycle(1'b0, 1'b1, 32'h1234_5037);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_imm",   signExtnImmediate, 32'h0);
    check("rst_type",  32'(imm_type), 32'h0);

    // Directed vectors
    directed(32'h0070_0013, 32'h0000_0007, 3'd1);
    directed(32'hE070_0013, 32'hFFFF_FE07, 3'd1);
    directed(32'hE070_0023, 32'hFFFF_FE00, 3'd2);
    directed(32'h0070_01A3, 32'h0000_0003, 3'd2);
    directed(32'h0000_0163, 32'h0000_0001, 3'd3);
    directed(32'h0200_0063, 32'h0000_0010, 3'd3);
    directed(32'h0000_00E3, 32'h0000_0400, 3'd3);
    directed(32'h8000_0063, 32'hFFFF_F800, 3'd3);
    directed(32'h0200_0033, 32'h0000_0000, 3'd0);
    directed(32'hFFFF_FFFF, 32'h0000_0000, 3'd7);
    directed(32'h1234_5037, 32'h1234_5000, 3'd4);
    directed(32'h8000_006F, 32'hFFF8_0000, 3'd5);

    // Valid stream, one bubble: immediate must hold
    directed(32'hE070_0013, 32'hFFFF_FE07, 3'd1);
    drive_cycle(1'b1, 1'b0, 32'h0000_0163);
    check("bubble_valid", 32'(out_valid), 32'h0);
    check("bubble_hold",  signExtnImmediate, 32'hFFFF_FE07);
    directed(32'h0000_0163, 32'h0000_0001, 3'd3);

    // Mid-stream reset discards the pending result
    drive_cycle(1'b0, 1'b1, 32'h8000_006F);
    check("midrst_imm", signExtnImmediate, 32'h0);
    check("midrst_valid", 32'(out_valid), 32'h0);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      ins = $urandom();
      if ($urandom_range(0, 3) != 0)
        ins[6:0] = ops[$urandom_range(0, 11)];
      drive_cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), ins);
    end

    // Only immediate bits matter: vary rd/rs/funct fields of an I-type
    ins = 32'h8000_0013;
    drive_cycle(1'b1, 1'b1, ins);
    held = signExtnImmediate;
    drive_cycle(1'b1, 1'b1, ins | 32'h000F_FF80);
    check("ignore_fields", signExtnImmediate, 32'hFFFF_F800);
    check("ignore_first",  held, 32'hFFFF_F800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
